// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, full 2*WIDTH
// product, per-operation signed/unsigned selection. start/busy/done handshake
// with back-to-back issue (a start seen in the DONE cycle is accepted).
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      product_q, product_d;
  logic signed [WIDTH+1:0] acc_q, acc_d;
  logic signed [WIDTH+1:0] m_q, m_d;
  logic [WIDTH:0]          q_q, q_d;
  logic                    q1_q, q1_d;
  logic signed [WIDTH+1:0] acc_sum;
  logic signed [WIDTH:0]   ext_a;
  logic                    accept;
  logic                    last_step;

  // Extend an operand by one bit so unsigned values become non-negative
  // signed values and both modes share the same signed Booth datapath.
  function automatic logic signed [WIDTH:0] ext_op(input logic [WIDTH-1:0] v,
                                                   input logic sm);
    ext_op = {sm & v[WIDTH-1], v};
  endfunction

  assign accept    = start && (state_q != RUN);
  assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(1));
  assign ext_a     = ext_op(a, signed_mode);

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

  // Control: next state and iteration counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_W'(WIDTH + 1);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_W'(WIDTH + 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load on accept, one add/subtract-and-shift per RUN cycle,
  // product captured from the shifted result of the final step.
  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    product_d = product_q;
    case ({q_q[0], q1_q})
      2'b01:   acc_sum = acc_q + m_q;
      2'b10:   acc_sum = acc_q - m_q;
      default: acc_sum = acc_q;
    endcase
    if (accept) begin
      acc_d = '0;
      q_d   = ext_op(b, signed_mode);
      q1_d  = 1'b0;
      m_d   = {ext_a[WIDTH], ext_a};
    end else if (state_q == RUN) begin
      acc_d = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
      q_d   = {acc_sum[0], q_q[WIDTH:1]};
      q1_d  = q_q[0];
      if (last_step) product_d = {acc_d[WIDTH-2:0], q_d};
    end
  end

  // Control registers and the visible product; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Working registers need no reset: they are always loaded on accept.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    q_q   <= q_d;
    q1_q  <= q1_d;
    m_q   <= m_d;
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: WIDTH=4 and WIDTH=8 instances, directed
// cases plus random operands checked against plain integer multiplication.
module tb_booth_multiplier_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       s4, sm4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       s8, sm8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(s4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(p4)
  );

  booth_multiplier_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(p8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact product of the two w-bit operands, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                          input logic [31:0] av, input logic [31:0] bv);
    longint x, y, mask;
    mask = (longint'(1) << w) - 1;
    x = longint'(av) & mask;
    y = longint'(bv) & mask;
    if (sm && av[w-1]) x = x - (longint'(1) << w);
    if (sm && bv[w-1]) y = y - (longint'(1) << w);
    return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic [63:0] get_prod(input int w);
    return (w == 4) ? {56'd0, p4} : {48'd0, p8};
  endfunction

  task automatic drive(input int w, input bit st, input bit sm,
                       input logic [31:0] av, input logic [31:0] bv);
    if (w == 4) begin
      s4 = st; sm4 = sm; a4 = av[3:0]; b4 = bv[3:0];
    end else begin
      s8 = st; sm8 = sm; a8 = av[7:0]; b8 = bv[7:0];
    end
  endtask

  // Issue one operation at the current negedge and wait (bounded) for done.
  task automatic do_op(input int w, input bit sm, input logic [31:0] av,
                       input logic [31:0] bv, input string tag);
    int lat;
    bit busy_ok, held_ok, ovl_ok;
    logic [63:0] prev;
    prev = get_prod(w);
    lat = 0; busy_ok = 1'b1; held_ok = 1'b1; ovl_ok = 1'b1;
    drive(w, 1'b1, sm, av, bv);
    for (int c = 1; c <= w + 8; c++) begin
      @(negedge clk);
      if (c == 1) drive(w, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (get_busy(w) && get_done(w)) ovl_ok = 1'b0;
      if (get_done(w)) begin
        lat = c;
        break;
      end
      if (!get_busy(w)) busy_ok = 1'b0;
      if (get_prod(w) !== prev) held_ok = 1'b0;
    end
    chk({tag, " latency"}, 64'(lat), 64'(w + 2));
    chk({tag, " product"}, get_prod(w), ref_mul(w, sm, av, bv));
    chk({tag, " busy/hold/overlap"}, {61'd0, busy_ok, held_ok, ovl_ok}, 64'd7);
  endtask

  logic [7:0] exp_b2b [3];
  logic [3:0] opa [3];
  logic [3:0] opb [3];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, ndone, dcyc;
    logic [7:0] last, seen;
    bit stable;
    logic [7:0] corner [5];

    exp_b2b[0] = 8'h0F; exp_b2b[1] = 8'hF4; exp_b2b[2] = 8'h00;
    opa[0] = 4'h3; opa[1] = 4'hE; opa[2] = 4'h0;
    opb[0] = 4'h5; opb[1] = 4'h6; opb[2] = 4'hF;
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'hFF;

    rst = 1'b1;
    drive(4, 1'b0, 1'b0, 0, 0);
    drive(8, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset w4 busy/done/product", {54'd0, busy4, done4, p4}, 64'd0);
    chk("reset w8 busy/done/product", {46'd0, busy8, done8, p8}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=4 cases.
    do_op(4, 1'b1, 4'h8, 4'h8, "w4 s -8*-8");
    chk("w4 s -8*-8 const", {56'd0, p4}, 64'h40);
    do_op(4, 1'b1, 4'h7, 4'h8, "w4 s 7*-8");
    chk("w4 s 7*-8 const", {56'd0, p4}, 64'hC8);
    do_op(4, 1'b0, 4'hF, 4'hF, "w4 u F*F");
    chk("w4 u F*F const", {56'd0, p4}, 64'hE1);
    do_op(4, 1'b1, 4'hF, 4'hF, "w4 s F*F");
    chk("w4 s F*F const", {56'd0, p4}, 64'h01);
    @(negedge clk);
    chk("w4 done single pulse / product held", {55'd0, done4, p4}, 64'h01);

    // Back-to-back with start held high.
    nd = 0; stable = 1'b1;
    drive(4, 1'b1, 1'b1, 32'(opa[0]), 32'(opb[0]));
    last = p4;
    for (int c = 1; c <= 40 && nd < 3; c++) begin
      @(negedge clk);
      if (done4) begin
        chk("b2b spacing", 64'(c), 64'(6 * (nd + 1)));
        chk("b2b product", {56'd0, p4}, {56'd0, exp_b2b[nd]});
        last = p4;
        nd++;
        if (nd < 3) drive(4, 1'b1, 1'b1, 32'(opa[nd]), 32'(opb[nd]));
        else drive(4, 1'b0, 1'b1, 0, 0);
      end else if (p4 !== last) begin
        stable = 1'b0;
      end
    end
    chk("b2b done count", 64'(nd), 64'd3);
    chk("b2b product stable", {63'd0, stable}, 64'd1);

    // Start while busy must be ignored.
    @(negedge clk);
    ndone = 0; dcyc = 0; seen = 8'h00;
    drive(4, 1'b1, 1'b1, 4'h5, 4'h3);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 2 || c == 4) drive(4, 1'b1, 1'b1, 4'hF, 4'h7);
      else drive(4, 1'b0, 1'b0, 4'h9, 4'h9);
      if (done4) begin
        ndone++;
        dcyc = c;
        seen = p4;
      end
    end
    chk("busy-start done count", 64'(ndone), 64'd1);
    chk("busy-start done cycle", 64'(dcyc), 64'd6);
    chk("busy-start product", {56'd0, seen}, 64'h0F);

    // Reset mid-operation, with start asserted in the same cycle.
    drive(4, 1'b1, 1'b0, 4'h3, 4'h3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) drive(4, 1'b0, 1'b0, 0, 0);
    end
    rst = 1'b1;
    drive(4, 1'b1, 1'b1, 4'h6, 4'h6);
    @(negedge clk);
    chk("mid-reset busy/done/product", {54'd0, busy4, done4, p4}, 64'd0);
    rst = 1'b0;
    drive(4, 1'b0, 1'b0, 0, 0);
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("mid-reset no done", 64'(ndone), 64'd0);
    do_op(4, 1'b1, 4'h9, 4'h6, "w4 after reset");

    // WIDTH=8 corners in both modes.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          do_op(8, 1'(m), 32'(corner[i]), 32'(corner[j]), "w8 corner");

    // Random operands.
    for (int k = 0; k < 400; k++) do_op(8, 1'b1, $urandom, $urandom, "w8 s rnd");
    for (int k = 0; k < 400; k++) do_op(8, 1'b0, $urandom, $urandom, "w8 u rnd");
    for (int k = 0; k < 100; k++)
      do_op(4, 1'($urandom_range(0, 1)), $urandom, $urandom, "w4 rnd");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
